// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU request sequencer and its ALU peer.
// Opcode encodings here are the ones the serial ALU decodes from its opcode pin pairs.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OpAdd  = 2'b00,
        OpSub  = 2'b01,
        OpPar  = 2'b10,
        OpComp = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StOpa,
        StOpb,
        StWait,
        StResp,
        StRelease
    } seq_state_e;

    // RELEASE must last at least this long so the ALU can fall back to IDLE.
    localparam int unsigned RelMinCycles = 2;

endpackage

// File: rtl/alu_seq_timer.sv
// Clear/enable counter that stops at and flags a terminal count.
// Used by alu_op_sequencer only when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_timer #(
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CntW = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);

    logic [CntW-1:0] count_q;

    assign terminal = (count_q == CntW'(TERMINAL));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !terminal) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Serialises one ALU request onto the simple_alu pin protocol and returns its response.
// Optional WAIT-state abort is compiled in with the ALU_SEQ_TIMEOUT_EN macro.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_err,
    output logic                  alu_opcode_valid,
    output logic                  alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  alu_done,
    input  logic                  alu_overflow,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    localparam int unsigned RelCntW = $clog2(RelMinCycles + 1);

    seq_state_e            state_q, state_d;
    alu_op_e               op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  overflow_q;
    logic [RelCntW-1:0]    rel_cnt_q;
    logic                  rel_low_q;
    logic                  rel_done;
    logic                  capture;
    logic                  abort;
    logic                  timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic timer_terminal;
    logic err_q;

    alu_seq_timer #(
        .TERMINAL(TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == StOpb),
        .enable  (state_q == StWait),
        .terminal(timer_terminal)
    );

    assign timeout = timer_terminal && (state_q == StWait);
    assign rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // Leave RELEASE only after the minimum dwell and once done has been seen low.
    assign rel_done = (rel_cnt_q >= RelCntW'(RelMinCycles - 1)) && (rel_low_q || !alu_done);

    assign rsp_result   = result_q;
    assign rsp_overflow = overflow_q;

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        alu_opcode_valid = 1'b0;
        alu_opcode       = 1'b0;
        alu_data         = '0;
        capture          = 1'b0;
        abort            = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StArm;
            end
            StArm, StOpa: begin
                alu_opcode_valid = 1'b1;
                alu_data         = a_q;
                alu_opcode       = op_q[0];
                state_d          = (state_q == StArm) ? StOpa : StOpb;
            end
            StOpb: begin
                alu_opcode_valid = 1'b1;
                alu_data         = b_q;
                alu_opcode       = op_q[1];
                state_d          = StWait;
            end
            StWait: begin
                alu_opcode_valid = 1'b1;
                alu_data         = b_q;
                alu_opcode       = op_q[1];
                if (alu_done) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else if (timeout) begin
                    abort   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid        = 1'b1;
                alu_opcode_valid = 1'b1;
                alu_data         = b_q;
                alu_opcode       = op_q[1];
                if (rsp_ready) state_d = StRelease;
            end
            StRelease: begin
                if (rel_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OpAdd;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            rel_cnt_q  <= '0;
            rel_low_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                op_q <= alu_op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (capture) begin
                result_q   <= alu_result;
                overflow_q <= alu_overflow;
            end else if (abort) begin
                result_q   <= '0;
                overflow_q <= 1'b0;
            end
            if (state_q != StRelease) begin
                rel_cnt_q <= '0;
                rel_low_q <= 1'b0;
            end else begin
                if (rel_cnt_q != RelCntW'(RelMinCycles)) rel_cnt_q <= rel_cnt_q + 1'b1;
                if (!alu_done) rel_low_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer with a behavioural serial-ALU peer and reference model.
// Timeout cases run only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_a, req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_err;
    logic          alu_opcode_valid;
    logic          alu_opcode;
    logic [DW-1:0] alu_data;
    logic          alu_done;
    logic          alu_overflow;
    logic [DW-1:0] alu_result;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int alu_delay = 3;  // 0 means the ALU never raises done
    int last_accept = 0;

    // Pin values seen by the ALU model for the most recent request.
    logic [DW-1:0] pa1, pa2, pb;
    logic          po0, po1, po2;

    alu_op_sequencer #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_overflow    (rsp_overflow),
        .rsp_err         (rsp_err),
        .alu_opcode_valid(alu_opcode_valid),
        .alu_opcode      (alu_opcode),
        .alu_data        (alu_data),
        .alu_done        (alu_done),
        .alu_overflow    (alu_overflow),
        .alu_result      (alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW:0] r;
        r = '0;
        case (alu_op_e'(op))
            OpAdd:   r = {1'b0, a} + {1'b0, b};
            OpSub:   r = {(a < b), a - b};
            OpPar:   r[0] = ^{a, b};
            default: begin r[0] = (a == b); r[DW] = (a < b); end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial ALU: takes A,A,B on three valid cycles, raises done alu_delay cycles later,
    // holds it while opcode_valid stays high, and shows garbage on result otherwise.
    initial begin
        logic          v, o, nxt_done;
        logic [DW-1:0] d;
        logic [DW:0]   res;
        int            nsamp, cnt;
        alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
        nsamp = 0; cnt = -1; res = '0;
        forever begin
            @(negedge clk);
            v = alu_opcode_valid; o = alu_opcode; d = alu_data;
            nxt_done = alu_done;
            if (v !== 1'b1) begin
                nsamp = 0; cnt = -1; nxt_done = 1'b0;
            end else if (nsamp < 3) begin
                case (nsamp)
                    0: begin pa1 = d; po0 = o; end
                    1: begin pa2 = d; po1 = o; end
                    default: begin pb = d; po2 = o; end
                endcase
                nsamp++;
                if (nsamp == 3) begin
                    res = ref_alu({po2, po0}, pa1, pb);
                    cnt = (alu_delay > 0) ? alu_delay - 1 : -1;
                    if (cnt == 0) nxt_done = 1'b1;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) nxt_done = 1'b1;
            end
            @(posedge clk);
            #1;
            alu_done = nxt_done;
            if (nxt_done) begin
                alu_result = res[DW-1:0]; alu_overflow = res[DW];
            end else begin
                alu_result = DW'($urandom); alu_overflow = 1'($urandom);
            end
        end
    end

    task automatic run_req(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int delay, input int hold);
        int          waitc, acc;
        logic [DW:0] e;
        logic        to;
        to = (delay == 0);
        e = to ? '0 : ref_alu(op, a, b);
        alu_delay = delay;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
        check("accept_bound", 32'(waitc < 50), 1);
        acc = cyc;
        last_accept = acc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        waitc = 0;
        do begin @(negedge clk); waitc++; end while (rsp_valid !== 1'b1 && waitc < 60);
        check("rsp_bound", rsp_valid, 1);
        check("latency", 32'(cyc - acc), to ? 32'(TO + 5) : 32'(delay + 4));
        check("result", rsp_result, e[DW-1:0]);
        check("overflow", rsp_overflow, e[DW]);
        check("err", rsp_err, to);
        check("pins_a", {pa1, pa2}, {a, a});
        check("pins_b", pb, b);
        check("pins_op", {po0, po1, po2}, {op[0], op[0], op[1]});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", rsp_valid, 1);
                check("hold_data", {rsp_err, rsp_overflow, rsp_result}, {to, e});
                check("hold_alu_valid", alu_opcode_valid, 1);
                check("hold_req_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rel_rsp_valid", rsp_valid, 0);
            check("rel_alu_pins", {alu_opcode_valid, alu_opcode, alu_data}, 0);
            waitc = 1;
            while (req_ready !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
            check("release_len", waitc, 3);
            check("rsp_held", {rsp_overflow, rsp_result}, e);
        end else begin
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int seen, acc1;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", {rsp_err, rsp_overflow, rsp_result}, 0);
        check("rst_alu_pins", {alu_opcode_valid, alu_opcode, alu_data}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_req(OpAdd, 8'h7F, 8'h01, 3, 0);
        check("tp_add_7f_01", {rsp_err, rsp_overflow, rsp_result}, 10'h080);
        run_req(OpAdd, 8'hFF, 8'h02, 3, 0);
        check("tp_add_ff_02", {rsp_overflow, rsp_result}, 9'h101);
        run_req(OpSub, 8'h05, 8'h07, 3, 2);
        check("tp_sub_05_07", {rsp_overflow, rsp_result}, 9'h1FE);
        run_req(OpComp, 8'h10, 8'h10, 3, 20);

        // Back-to-back with rsp_ready high: second request waits through RELEASE.
        run_req(OpPar, 8'h5A, 8'h3C, 3, 0);
        acc1 = last_accept;
        run_req(OpSub, 8'h80, 8'h01, 3, 0);
        check("b2b_period", 32'(last_accept - acc1), 10);

        // Reset while the sequencer is driving B.
        alu_delay = 3;
        req_op = OpComp; req_a = 8'hAA; req_b = 8'h55; req_valid = 1'b1;
        seen = 0;
        while (req_ready !== 1'b1 && seen < 50) begin @(negedge clk); seen++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("opb_pins", {alu_opcode_valid, alu_opcode, alu_data}, {1'b1, 1'b1, 8'h55});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_idle", {req_ready, rsp_valid, alu_opcode_valid}, 3'b100);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        check("midrst_no_rsp", seen, 0);
        run_req(OpAdd, 8'h01, 8'h01, 3, 1);
        check("midrst_add", rsp_result, 8'h02);

`ifdef ALU_SEQ_TIMEOUT_EN
        run_req(OpAdd, 8'h12, 8'h34, 0, 1);
        check("timeout_err", {rsp_err, rsp_result}, 9'h100);
        run_req(OpAdd, 8'h12, 8'h34, TO + 1, 1);
        check("done_beats_timeout", {rsp_err, rsp_result}, 9'h046);
`endif

        for (int n = 0; n < 40; n++) begin
            run_req(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
                    $urandom_range(1, 8), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream driver for the serial-protocol `simple_alu`. It accepts a complete ALU request (two operands and a 2-bit opcode) on a valid/ready handshake and serialises it onto the ALU's `opcode_valid`/`opcode`/`data` pins. It captures `result` and `overflow` when `done` is seen, then returns them on a response handshake. It sits between the test/host request source and the ALU.

## Interface
- `DATA_WIDTH`, 8: operand/result width; must match the ALU.
- `TIMEOUT`, 15: cycles in WAIT without `done` before abort (only with `ALU_SEQ_TIMEOUT_EN`).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  2  opcode: 00 ADD, 01 SUB, 10 PAR, 11 COMP.
- `req_a`, `req_b`  in  DATA_WIDTH  operands A and B.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  DATA_WIDTH  captured ALU `result`.
- `rsp_overflow`  out  1  captured ALU `overflow`.
- `rsp_err`  out  1  timeout abort. Tied 0 when the timeout feature is compiled out.
- `alu_opcode_valid`  out  1  to ALU `opcode_valid`.
- `alu_opcode`  out  1  to ALU `opcode`.
- `alu_data`  out  DATA_WIDTH  to ALU `data`.
- `alu_done`  in  1  from ALU `done`.
- `alu_overflow`  in  1  from ALU `overflow`.
- `alu_result`  in  DATA_WIDTH  from ALU `result`.

## Operation
States and transitions:
- **IDLE**
  - `req_ready`=1, all `alu_*` outputs 0.
  - On `req_valid & req_ready`, latch `req_a`, `req_b`, `req_op`, then go to ARM.
- **ARM**
  - Drive `alu_opcode_valid`=1, `alu_data`=A, `alu_opcode`=op[0].
  - Stay one cycle, then go to OPA.
- **OPA**
  - Outputs are the same as ARM, giving A two full edges.
  - Go to OPB.
- **OPB**
  - Drive `alu_opcode_valid`=1, `alu_data`=B, `alu_opcode`=op[1].
  - Go to WAIT.
- **WAIT**
  - Hold OPB outputs.
  - On `alu_done`=1: capture `alu_result` and `alu_overflow`, `rsp_err`=0, go to RESP.
  - If the timeout counter reaches TIMEOUT: result=0, overflow=0, `rsp_err`=1, go to RESP.
- **RESP**
  - `rsp_valid`=1. `alu_opcode_valid` is held at 1 so the ALU stays in DONE.
  - On `rsp_ready`, go to RELEASE.
- **RELEASE**
  - `alu_opcode_valid`=0, `alu_data`=0, `alu_opcode`=0.
  - Stay until `alu_done`=0 has been sampled at least once, with a minimum of 2 cycles so the ALU returns to IDLE.
  - Then go to IDLE.

Rules:
- `req_ready` is 1 only in IDLE. Exactly one request is in flight at a time.
- `rsp_*` outputs are stable while `rsp_valid`=1 and `rsp_ready`=0.
- The captured result is not modified by later ALU activity.
- A request arriving during RELEASE waits; it is not dropped.
- Response data is held until the next capture.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_err`=0, `alu_opcode_valid`=0, `alu_opcode`=0, `alu_data`=0.
- Reset mid-operation forces IDLE on the next edge. `alu_opcode_valid` drops to 0, which returns the ALU to IDLE. The in-flight request is discarded and no response is produced.
- Latency:
  - Request accept to first `alu_opcode_valid`=1 is 1 cycle.
  - `alu_done` to `rsp_valid`=1 is 1 cycle.
  - Nominal accept-to-response is 7 cycles with the current ALU.
- Back-to-back minimum period: 10 cycles with `rsp_ready` held at 1.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle. Abort when count == TIMEOUT.
- If `alu_done` and the timeout occur in the same cycle, `alu_done` wins.

## Configuration
- `ALU_SEQ_TIMEOUT_EN`
  - Defined: the timeout counter exists and WAIT can abort with `rsp_err`=1.
  - Undefined: no counter, WAIT exits only on `alu_done`, and `rsp_err` is constant 0.

## Structure
- `alu_seq_pkg` holds:
  - the opcode enum (ADD/SUB/PAR/COMP = 2'b00/01/10/11);
  - the state enum (IDLE, ARM, OPA, OPB, WAIT, RESP, RELEASE);
  - the RELEASE minimum-cycle constant.
- The ALU should also adopt the package's opcode constants.
- One sub-module, `alu_seq_timer`: a clear/enable/terminal-count counter, instantiated only under `ALU_SEQ_TIMEOUT_EN`.

## Test plan
- ADD, A=0x7F, B=0x01 -> `rsp_result`=0x80, `rsp_overflow`=0, `rsp_err`=0.
- ADD, A=0xFF, B=0x02 -> `rsp_result`=0x01, `rsp_overflow`=1.
- SUB, A=0x05, B=0x07 -> `rsp_result`=0xFE, `rsp_overflow`=1. Check the ALU pin sequence A,A,B with opcode bits 1,1,0.
- Back-pressure: COMP, A=0x10, B=0x10, `rsp_ready`=0 for 20 cycles -> `rsp_valid` and data stable throughout, `alu_opcode_valid` stays 1, `req_ready`=0. Then raise `rsp_ready` -> RELEASE, then IDLE.
- Reset asserted during OPB, then an ADD 0x01+0x01 -> no response for the first request; the second returns 0x02 with the nominal 7-cycle latency.
- With `ALU_SEQ_TIMEOUT_EN`, `alu_done` forced to 0 -> `rsp_valid` rises TIMEOUT+1 cycles after WAIT entry, with `rsp_err`=1 and `rsp_result`=0x00.
